// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle RV32 controller: state encoding, opcodes
// and the select/opcode encodings seen by the datapath muxes and the ALU decoder.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_JALR_ADR = 4'd11,
      S_JALR_JMP = 4'd12,
      S_LUI      = 4'd13,
      S_HALT     = 4'd14
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_IMMEXT    = 2'b11;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   function automatic logic op_is_known(input logic [6:0] op_i);
      logic known;
      case (op_i)
         OP_LW, OP_SW, OP_RTYPE, OP_IALU,
         OP_BEQ, OP_JAL, OP_JALR, OP_LUI: known = 1'b1;
         default:                         known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_imm_src_dec.sv
// Opcode to immediate-format decoder; shared with the single-cycle datapath.
module imm_src_dec
   import ctrl_pkg::*;
(
   input  logic [6:0] op,
   output logic [2:0] imm_src
);

   always_comb begin
      imm_src = IMM_I;
      case (op)
         OP_SW:   imm_src = IMM_S;
         OP_BEQ:  imm_src = IMM_B;
         OP_JAL:  imm_src = IMM_J;
         OP_LUI:  imm_src = IMM_U;
         default: imm_src = IMM_I;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32 sequencing controller: walks each instruction through its
// fetch/decode/execute/writeback states and drives the datapath controls.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter bit HAS_MEM_HANDSHAKE = 1'b1,
   parameter bit ILLEGAL_HALT      = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [2:0] ImmSrc,
   output logic [1:0] ALUOp,
   output logic       retire,
   output logic       illegal_op,
   output logic       halted
);

   state_t state_q;
   state_t state_d;

   logic       mem_rdy;
   logic       adr_src;
   logic       ir_write;
   logic       pc_update;
   logic       branch;
   logic       reg_write;
   logic       mem_write;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] alu_op;
   logic       retire_raw;
   logic       illegal_raw;
   logic       halted_raw;

   assign mem_rdy = HAS_MEM_HANDSHAKE ? mem_ready : 1'b1;

   imm_src_dec u_imm_src_dec (
      .op      (op),
      .imm_src (ImmSrc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (mem_rdy) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECR;
               OP_IALU:      state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               OP_JALR:      state_d = S_JALR_ADR;
               OP_LUI:       state_d = S_LUI;
               default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
            endcase
         end
         S_MEMADR: begin
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            if (mem_rdy) begin
               state_d = S_MEMWB;
            end
         end
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: begin
            if (mem_rdy) begin
               state_d = S_FETCH;
            end
         end
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_JALR_ADR: state_d = S_JALR_JMP;
         S_JALR_JMP: state_d = S_ALUWB;
         S_LUI:      state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase
   end

   // Moore decode; only the FETCH and MEMWRITE enables also look at mem_ready.
   always_comb begin
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_update   = 1'b0;
      branch      = 1'b0;
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RD2;
      result_src  = RES_ALUOUT;
      alu_op      = ALUOP_ADD;
      retire_raw  = 1'b0;
      illegal_raw = 1'b0;
      halted_raw  = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            ir_write   = mem_rdy;
            pc_update  = mem_rdy;
         end
         S_DECODE: begin
            alu_src_a   = SRCA_OLDPC;
            alu_src_b   = SRCB_IMM;
            illegal_raw = ~op_is_known(op);
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            retire_raw = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            retire_raw = mem_rdy;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RD1;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            retire_raw = 1'b1;
         end
         S_BEQ: begin
            alu_src_a  = SRCA_RD1;
            alu_op     = ALUOP_SUB;
            branch     = 1'b1;
            retire_raw = 1'b1;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
         end
         S_JALR_ADR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
         end
         S_JALR_JMP: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
         end
         S_LUI: begin
            result_src = RES_IMMEXT;
            reg_write  = 1'b1;
            retire_raw = 1'b1;
         end
         S_HALT: begin
            halted_raw = 1'b1;
         end
         default: begin
            halted_raw = 1'b0;
         end
      endcase
   end

   // Write enables and pulses are suppressed for the whole reset cycle so an
   // abandoned instruction can never commit anything.
   assign AdrSrc     = adr_src;
   assign IRWrite    = ir_write & ~reset;
   assign PCWrite    = ((branch & Zero) | pc_update) & ~reset;
   assign RegWrite   = reg_write & ~reset;
   assign MemWrite   = mem_write & ~reset;
   assign ALUSrcA    = alu_src_a;
   assign ALUSrcB    = alu_src_b;
   assign ResultSrc  = result_src;
   assign ALUOp      = alu_op;
   assign retire     = retire_raw & ~reset;
   assign illegal_op = illegal_raw & ~reset;
   assign halted     = halted_raw;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm; one instance with default parameters
// and one with ILLEGAL_HALT=1 share the same stimulus.
module tb_multicycle_ctrl_fsm;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_BAD  = 7'b1111111;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic       zero;
   logic       memReady;

   logic       adrSrc, irWrite, pcWrite, regWrite, memWrite;
   logic [1:0] aluSrcA, aluSrcB, resultSrc, aluOp;
   logic [2:0] immSrc;
   logic       retire, illegalOp, halted;

   logic       adrSrcH, irWriteH, pcWriteH, regWriteH, memWriteH;
   logic [1:0] aluSrcAH, aluSrcBH, resultSrcH, aluOpH;
   logic [2:0] immSrcH;
   logic       retireH, illegalOpH, haltedH;

   logic [18:0] obs;
   logic [18:0] obsH;

   int compareCount;
   int failCount;

   multicycle_ctrl_fsm dut (
      .clk(clk), .reset(reset), .op(op), .Zero(zero), .mem_ready(memReady),
      .AdrSrc(adrSrc), .IRWrite(irWrite), .PCWrite(pcWrite), .RegWrite(regWrite),
      .MemWrite(memWrite), .ALUSrcA(aluSrcA), .ALUSrcB(aluSrcB), .ResultSrc(resultSrc),
      .ImmSrc(immSrc), .ALUOp(aluOp), .retire(retire), .illegal_op(illegalOp),
      .halted(halted)
   );

   multicycle_ctrl_fsm #(.HAS_MEM_HANDSHAKE(1'b1), .ILLEGAL_HALT(1'b1)) dutHalt (
      .clk(clk), .reset(reset), .op(op), .Zero(zero), .mem_ready(memReady),
      .AdrSrc(adrSrcH), .IRWrite(irWriteH), .PCWrite(pcWriteH), .RegWrite(regWriteH),
      .MemWrite(memWriteH), .ALUSrcA(aluSrcAH), .ALUSrcB(aluSrcBH), .ResultSrc(resultSrcH),
      .ImmSrc(immSrcH), .ALUOp(aluOpH), .retire(retireH), .illegal_op(illegalOpH),
      .halted(haltedH)
   );

   assign obs  = {adrSrc, irWrite, pcWrite, regWrite, memWrite, aluSrcA, aluSrcB,
                  resultSrc, immSrc, aluOp, retire, illegalOp, halted};
   assign obsH = {adrSrcH, irWriteH, pcWriteH, regWriteH, memWriteH, aluSrcAH, aluSrcBH,
                  resultSrcH, immSrcH, aluOpH, retireH, illegalOpH, haltedH};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Field order: AdrSrc IRWrite PCWrite RegWrite MemWrite SrcA SrcB ResultSrc ImmSrc ALUOp retire illegal halted
   function automatic logic [18:0] mk(input logic adr, input logic irw, input logic pcw,
                                      input logic rw, input logic mw, input logic [1:0] srcA,
                                      input logic [1:0] srcB, input logic [1:0] res,
                                      input logic [2:0] imm, input logic [1:0] aop,
                                      input logic ret, input logic ill, input logic hlt);
      return {adr, irw, pcw, rw, mw, srcA, srcB, res, imm, aop, ret, ill, hlt};
   endfunction

   function automatic logic [18:0] expFetch(input logic [2:0] imm, input logic rdy);
      return mk(1'b0, rdy, rdy, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, imm, 2'b00, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic logic [18:0] expDecode(input logic [2:0] imm, input logic ill);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, imm, 2'b00, 1'b0, ill, 1'b0);
   endfunction

   function automatic logic [18:0] expAdr(input logic [2:0] imm);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, imm, 2'b00, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic logic [18:0] expAluWb(input logic [2:0] imm);
      return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, imm, 2'b00, 1'b1, 1'b0, 1'b0);
   endfunction

   function automatic logic [18:0] expHalt(input logic [2:0] imm);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 2'b00, 1'b0, 1'b0, 1'b1);
   endfunction

   // Inputs change on the falling edge and outputs are sampled 1ns later.
   task automatic applyStimulus(input logic rst, input logic [6:0] opV,
                                input logic zeroV, input logic rdyV);
      @(negedge clk);
      reset    = rst;
      op       = opV;
      zero     = zeroV;
      memReady = rdyV;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [18:0] observed,
                              input logic [18:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
      end
   endtask

   initial begin
      reset        = 1'b1;
      op           = OP_LW;
      zero         = 1'b0;
      memReady     = 1'b1;
      compareCount = 0;
      failCount    = 0;

      applyStimulus(1'b1, OP_LW, 1'b0, 1'b1);
      checkOutput("reset.fetch_forced", obs, expFetch(3'b000, 1'b0));
      checkOutput("reset.fetch_forced_h", obsH, expFetch(3'b000, 1'b0));

      // LW, no stalls: 5 cycles
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      checkOutput("lw.fetch", obs, expFetch(3'b000, 1'b1));
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      checkOutput("lw.decode", obs, expDecode(3'b000, 1'b0));
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      checkOutput("lw.memadr", obs, expAdr(3'b000));
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      checkOutput("lw.memread", obs, mk(1,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0));
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      checkOutput("lw.memwb", obs, mk(0,0,0,1,0,2'b00,2'b00,2'b01,3'b000,2'b00,1,0,0));

      // SW with three wait cycles in MEMWRITE
      applyStimulus(1'b0, OP_SW, 1'b0, 1'b1);
      checkOutput("sw.fetch", obs, expFetch(3'b001, 1'b1));
      applyStimulus(1'b0, OP_SW, 1'b0, 1'b1);
      checkOutput("sw.decode", obs, expDecode(3'b001, 1'b0));
      applyStimulus(1'b0, OP_SW, 1'b0, 1'b1);
      checkOutput("sw.memadr", obs, expAdr(3'b001));
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, OP_SW, 1'b0, 1'b0);
         checkOutput("sw.memwrite_wait", obs, mk(1,0,0,0,1,2'b00,2'b00,2'b00,3'b001,2'b00,0,0,0));
      end
      applyStimulus(1'b0, OP_SW, 1'b0, 1'b1);
      checkOutput("sw.memwrite_ready", obs, mk(1,0,0,0,1,2'b00,2'b00,2'b00,3'b001,2'b00,1,0,0));

      // BEQ taken then not taken
      applyStimulus(1'b0, OP_BEQ, 1'b1, 1'b1);
      checkOutput("beq1.fetch", obs, expFetch(3'b010, 1'b1));
      applyStimulus(1'b0, OP_BEQ, 1'b1, 1'b1);
      checkOutput("beq1.decode", obs, expDecode(3'b010, 1'b0));
      applyStimulus(1'b0, OP_BEQ, 1'b1, 1'b1);
      checkOutput("beq1.beq_taken", obs, mk(0,0,1,0,0,2'b10,2'b00,2'b00,3'b010,2'b01,1,0,0));
      applyStimulus(1'b0, OP_BEQ, 1'b0, 1'b1);
      checkOutput("beq0.fetch", obs, expFetch(3'b010, 1'b1));
      applyStimulus(1'b0, OP_BEQ, 1'b0, 1'b1);
      checkOutput("beq0.decode", obs, expDecode(3'b010, 1'b0));
      applyStimulus(1'b0, OP_BEQ, 1'b0, 1'b1);
      checkOutput("beq0.beq_not_taken", obs, mk(0,0,0,0,0,2'b10,2'b00,2'b00,3'b010,2'b01,1,0,0));

      // R-type and I-ALU
      applyStimulus(1'b0, OP_R, 1'b0, 1'b1);
      checkOutput("r.fetch", obs, expFetch(3'b000, 1'b1));
      applyStimulus(1'b0, OP_R, 1'b0, 1'b1);
      checkOutput("r.decode", obs, expDecode(3'b000, 1'b0));
      applyStimulus(1'b0, OP_R, 1'b0, 1'b1);
      checkOutput("r.execr", obs, mk(0,0,0,0,0,2'b10,2'b00,2'b00,3'b000,2'b10,0,0,0));
      applyStimulus(1'b0, OP_R, 1'b0, 1'b1);
      checkOutput("r.aluwb", obs, expAluWb(3'b000));
      applyStimulus(1'b0, OP_I, 1'b0, 1'b1);
      checkOutput("i.fetch", obs, expFetch(3'b000, 1'b1));
      applyStimulus(1'b0, OP_I, 1'b0, 1'b1);
      checkOutput("i.decode", obs, expDecode(3'b000, 1'b0));
      applyStimulus(1'b0, OP_I, 1'b0, 1'b1);
      checkOutput("i.execi", obs, mk(0,0,0,0,0,2'b10,2'b01,2'b00,3'b000,2'b10,0,0,0));
      applyStimulus(1'b0, OP_I, 1'b0, 1'b1);
      checkOutput("i.aluwb", obs, expAluWb(3'b000));

      // JALR: 5 cycles
      applyStimulus(1'b0, OP_JALR, 1'b0, 1'b1);
      checkOutput("jalr.fetch", obs, expFetch(3'b000, 1'b1));
      applyStimulus(1'b0, OP_JALR, 1'b0, 1'b1);
      checkOutput("jalr.decode", obs, expDecode(3'b000, 1'b0));
      applyStimulus(1'b0, OP_JALR, 1'b0, 1'b1);
      checkOutput("jalr.adr", obs, expAdr(3'b000));
      applyStimulus(1'b0, OP_JALR, 1'b0, 1'b1);
      checkOutput("jalr.jmp", obs, mk(0,0,1,0,0,2'b01,2'b10,2'b00,3'b000,2'b00,0,0,0));
      applyStimulus(1'b0, OP_JALR, 1'b0, 1'b1);
      checkOutput("jalr.aluwb", obs, expAluWb(3'b000));

      // JAL then LUI
      applyStimulus(1'b0, OP_JAL, 1'b0, 1'b1);
      checkOutput("jal.fetch", obs, expFetch(3'b011, 1'b1));
      applyStimulus(1'b0, OP_JAL, 1'b0, 1'b1);
      checkOutput("jal.decode", obs, expDecode(3'b011, 1'b0));
      applyStimulus(1'b0, OP_JAL, 1'b0, 1'b1);
      checkOutput("jal.jal", obs, mk(0,0,1,0,0,2'b01,2'b10,2'b00,3'b011,2'b00,0,0,0));
      applyStimulus(1'b0, OP_JAL, 1'b0, 1'b1);
      checkOutput("jal.aluwb", obs, expAluWb(3'b011));
      applyStimulus(1'b0, OP_LUI, 1'b0, 1'b1);
      checkOutput("lui.fetch", obs, expFetch(3'b100, 1'b1));
      applyStimulus(1'b0, OP_LUI, 1'b0, 1'b1);
      checkOutput("lui.decode", obs, expDecode(3'b100, 1'b0));
      applyStimulus(1'b0, OP_LUI, 1'b0, 1'b1);
      checkOutput("lui.lui", obs, mk(0,0,0,1,0,2'b00,2'b00,2'b11,3'b100,2'b00,1,0,0));

      // FETCH stalled five cycles, then LUI completes
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, OP_LUI, 1'b0, 1'b0);
         checkOutput("stall.fetch_wait", obs, expFetch(3'b100, 1'b0));
      end
      applyStimulus(1'b0, OP_LUI, 1'b0, 1'b1);
      checkOutput("stall.fetch_ready", obs, expFetch(3'b100, 1'b1));
      applyStimulus(1'b0, OP_LUI, 1'b0, 1'b1);
      checkOutput("stall.decode", obs, expDecode(3'b100, 1'b0));
      applyStimulus(1'b0, OP_LUI, 1'b0, 1'b1);
      checkOutput("stall.lui", obs, mk(0,0,0,1,0,2'b00,2'b00,2'b11,3'b100,2'b00,1,0,0));

      // LW with two wait cycles in MEMREAD
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      checkOutput("lwst.memadr", obs, expAdr(3'b000));
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, OP_LW, 1'b0, 1'b0);
         checkOutput("lwst.memread_wait", obs, mk(1,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0));
      end
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      checkOutput("lwst.memread_ready", obs, mk(1,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0));
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      checkOutput("lwst.memwb", obs, mk(0,0,0,1,0,2'b00,2'b00,2'b01,3'b000,2'b00,1,0,0));

      // Reset while waiting in MEMREAD abandons the load
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b0);
      checkOutput("rst.memread", obs, mk(1,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0));
      applyStimulus(1'b1, OP_LW, 1'b0, 1'b1);
      checkOutput("rst.memread_in_reset", obs, mk(1,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0));
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b0);
      checkOutput("rst.fetch_after", obs, expFetch(3'b000, 1'b0));

      // Reset during ALUWB must suppress RegWrite and retire
      applyStimulus(1'b0, OP_R, 1'b0, 1'b1);
      checkOutput("rst2.fetch", obs, expFetch(3'b000, 1'b1));
      applyStimulus(1'b0, OP_R, 1'b0, 1'b1);
      applyStimulus(1'b0, OP_R, 1'b0, 1'b1);
      checkOutput("rst2.execr", obs, mk(0,0,0,0,0,2'b10,2'b00,2'b00,3'b000,2'b10,0,0,0));
      applyStimulus(1'b1, OP_R, 1'b0, 1'b1);
      checkOutput("rst2.aluwb_forced", obs, mk(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0));
      applyStimulus(1'b0, OP_R, 1'b0, 1'b1);
      checkOutput("rst2.fetch_after", obs, expFetch(3'b000, 1'b1));

      // Unknown opcode: pulse and return vs sticky HALT
      applyStimulus(1'b0, OP_BAD, 1'b0, 1'b1);
      checkOutput("ill.decode", obs, expDecode(3'b000, 1'b1));
      checkOutput("illh.decode", obsH, expDecode(3'b000, 1'b1));
      applyStimulus(1'b0, OP_BAD, 1'b0, 1'b1);
      checkOutput("ill.fetch_next", obs, expFetch(3'b000, 1'b1));
      checkOutput("illh.halt", obsH, expHalt(3'b000));
      applyStimulus(1'b0, OP_LUI, 1'b0, 1'b1);
      checkOutput("ill.decode_lui", obs, expDecode(3'b100, 1'b0));
      checkOutput("illh.halt_sticky1", obsH, expHalt(3'b100));
      applyStimulus(1'b0, OP_LUI, 1'b0, 1'b1);
      checkOutput("ill.lui", obs, mk(0,0,0,1,0,2'b00,2'b00,2'b11,3'b100,2'b00,1,0,0));
      checkOutput("illh.halt_sticky2", obsH, expHalt(3'b100));
      applyStimulus(1'b1, OP_LW, 1'b0, 1'b1);
      checkOutput("illh.halt_in_reset", obsH, expHalt(3'b000));
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      checkOutput("illh.fetch_after_reset", obsH, expFetch(3'b000, 1'b1));
      checkOutput("ill.fetch_after_reset", obs, expFetch(3'b000, 1'b1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
